regfile_port_ctrl: RTL
======================

Name: regfile_port_ctrl

Overview:
- Control stage that sits directly upstream of the register-file latch cells (latch-with-dual-tristate-read-port elements).
- Converts write requests (rd, data) into a stable write-data bus plus per-register complementary latch strobes.
- Converts two read addresses (rs1, rs2) into per-register complementary one-hot read-port enables, with x0 handling and write-to-read forwarding.
- Guarantees the cells never see a shared-bus conflict or a data change while a latch is transparent.

Parameters:
- XLEN, 32, data width of the write bus and of each register.
- NREG, 32, number of architectural registers including x0; x0 has no latch cell.
- AW, 5, address width; NREG must be at most 2**AW.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- WVALID  in  1  write request valid.
- WREADY  out  1  write request accepted when WVALID and WREADY are both high at a rising edge.
- WADDR  in  AW  destination register (rd).
- WDATA  in  XLEN  write data.
- RVALID  in  1  capture read addresses this edge.
- RADDR1  in  AW  rs1.
- RADDR2  in  AW  rs2.
- D  out  XLEN  write-data bus to every cell D input.
- LCLK  out  NREG-1  per-register latch strobe for x1..x(NREG-1), active high.
- nLCLK  out  NREG-1  exact complement of LCLK.
- EN1  out  NREG-1  one-hot read-port-1 enables.
- nEN1  out  NREG-1  exact complement of EN1.
- EN2  out  NREG-1  one-hot read-port-2 enables.
- nEN2  out  NREG-1  exact complement of EN2.
- ZERO1  out  1  read port 1 must read as zero; the consumer applies pull-down/zero mux.
- ZERO2  out  1  read port 2 must read as zero.
- FWD1  out  1  port 1 is forwarded; the consumer takes D instead of Q1.
- FWD2  out  1  port 2 is forwarded; the consumer takes D instead of Q2.

Behaviour:
- **Reset:** while nRST is low, all outputs are forced asynchronously:
  - state = IDLE; WREADY = 1; D = 0.
  - LCLK = 0, nLCLK = all ones.
  - EN1 = EN2 = 0, nEN1 = nEN2 = all ones.
  - ZERO1 = ZERO2 = 1; FWD1 = FWD2 = 0.
- **Write FSM states:** IDLE, STROBE, HOLD.
- **IDLE:**
  - WREADY = 1.
  - On accept with WADDR != 0 and WADDR < NREG: capture the address into wa_q and WDATA into D, then go to STROBE.
  - On accept with WADDR = 0 or WADDR >= NREG: the request is consumed, no strobe occurs, D is unchanged, and the FSM stays in IDLE.
- **STROBE** (exactly one cycle):
  - LCLK[wa_q] = 1, all other LCLK bits 0.
  - D is held; WREADY = 0.
  - Next state is HOLD.
- **HOLD** (exactly one cycle):
  - LCLK = 0 and D is held, giving the cells hold time after the latch closes.
  - WREADY = 1; a write accepted here goes directly to STROBE with the new D/wa_q.
  - With no accept, go to IDLE.
- **Write throughput:** at most one write every 2 cycles. Latency from accept edge to strobe high is 1 cycle.
- **Complements:** LCLK/nLCLK, EN1/nEN1 and EN2/nEN2 are driven from the same registered source, so they are exact complements on every cycle. No bit is ever high in both members of a pair.
- **Read capture:**
  - On a rising edge with RVALID high, RADDR1/RADDR2 are registered.
  - Read outputs are a function of the registered addresses and the current write state. They are valid 1 cycle after capture and persist until the next capture.
- **Read decode per port k:**
  - If the address is 0 or >= NREG: ZEROk = 1, ENk = 0, FWDk = 0.
  - Else if the FSM is in STROBE or HOLD and the address equals wa_q: FWDk = 1, ENk = 0 (the cell is transparent or settling, so the bus is not enabled), ZEROk = 0.
  - Else: ENk = one-hot(address), ZEROk = 0, FWDk = 0.
- **Port independence:** both ports may address the same register; each asserts its own enable independently, since the cell has two separate tristate ports.
- **Read-enable timing:** enables change only on rising edges and never glitch. At most one bit of each ENk is set.
- **Reset mid-operation:** an asynchronous reset during STROBE drops LCLK immediately. The partial write is undefined in the cell, and the controller returns to IDLE.

Test Plan:
- Reset then release; write x5 = 0xDEADBEEF -> WREADY high at accept, next cycle LCLK = 1<<4 (bit for x5) with nLCLK its complement and D = 0xDEADBEEF, following cycle LCLK = 0 with D still 0xDEADBEEF, then IDLE.
- Back-to-back writes x1 = 0x11 then x2 = 0x22 with WVALID held high -> second accept occurs in HOLD; strobes for x1 and x2 are exactly 2 cycles apart; WREADY low only during STROBE.
- Write to x0 and to address >= NREG -> no LCLK bit ever set, D unchanged, FSM stays IDLE, WREADY stays 1.
- Read rs1 = 0, rs2 = 7 -> ZERO1 = 1 with EN1 = 0; EN2 = 1<<6 with nEN2 its complement; FWD1 = FWD2 = 0.
- Read rs1 = rs2 = 9 while a write to x9 is in STROBE -> FWD1 = FWD2 = 1 and EN1 = EN2 = 0. After return to IDLE, both enables switch to 1<<8 and both FWD outputs fall.
- Assert nRST low during STROBE -> LCLK = 0, nLCLK all ones, D = 0 and ZERO1 = ZERO2 = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_ctrl_if
// Description : Bundle between the register-file port controller and its
//               neighbours.
//               Write request : WVALID, WREADY, WADDR, WDATA
//               Read request  : RVALID, RADDR1, RADDR2
//               Cell controls : D, LCLK/nLCLK, EN1/nEN1, EN2/nEN2
//               Consumer flags: ZERO1, ZERO2, FWD1, FWD2
//               The slave modport belongs to the controller. The master
//               modport belongs to the requester and cell side.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_port_ctrl_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
);
  logic            WVALID;
  logic            WREADY;
  logic [AW-1:0]   WADDR;
  logic [XLEN-1:0] WDATA;
  logic            RVALID;
  logic [AW-1:0]   RADDR1;
  logic [AW-1:0]   RADDR2;
  logic [XLEN-1:0] D;
  logic [NREG-2:0] LCLK;
  logic [NREG-2:0] nLCLK;
  logic [NREG-2:0] EN1;
  logic [NREG-2:0] nEN1;
  logic [NREG-2:0] EN2;
  logic [NREG-2:0] nEN2;
  logic            ZERO1;
  logic            ZERO2;
  logic            FWD1;
  logic            FWD2;

  modport slave (
    input  WVALID, WADDR, WDATA, RVALID, RADDR1, RADDR2,
    output WREADY, D, LCLK, nLCLK, EN1, nEN1, EN2, nEN2,
           ZERO1, ZERO2, FWD1, FWD2
  );

  modport master (
    output WVALID, WADDR, WDATA, RVALID, RADDR1, RADDR2,
    input  WREADY, D, LCLK, nLCLK, EN1, nEN1, EN2, nEN2,
           ZERO1, ZERO2, FWD1, FWD2
  );
endinterface
`default_nettype wire

// File: rtl/regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_ctrl
// Description : Control stage in front of the latch-based register-file cells.
//               A write takes three steps. IDLE accepts the request. STROBE
//               opens the latch for one cycle. HOLD closes the latch while D
//               stays stable. Reads decode the registered rs1 and rs2
//               addresses into one-hot tristate enables. They also raise a
//               zero flag for x0 and for addresses out of range. They raise a
//               forward flag when the addressed register is being written.
//               Ports: CLK, nRST (async, active low), and bus (slave modport
//               of regfile_port_ctrl_if).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  wire logic           CLK,
  input  wire logic           nRST,
  regfile_port_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [AW:0] c_nreg = (AW+1)'(NREG);

  state_t          state_q, state_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [AW-1:0]   ra1_q, ra1_d;
  logic [AW-1:0]   ra2_q, ra2_d;
  logic [XLEN-1:0] d_q, d_d;
  logic [NREG-2:0] lclk_q, lclk_d;
  logic [NREG-2:0] en1_q, en1_d;
  logic [NREG-2:0] en2_q, en2_d;
  logic            zero1_q, zero1_d;
  logic            zero2_q, zero2_d;
  logic            fwd1_q, fwd1_d;
  logic            fwd2_q, fwd2_d;
  logic            wready;
  logic            wr_accept;

  // A register address is backed by a latch cell only for x1..x(NREG-1).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < c_nreg);
  endfunction

  // Bit (a-1) corresponds to register xa, because x0 has no cell.
  function automatic logic [NREG-2:0] onehot(input logic [AW-1:0] a);
    logic [NREG-2:0] v;
    v = '0;
    for (int i = 1; i < NREG; i++) begin
      if (a == AW'(i)) v[i-1] = 1'b1;
    end
    return v;
  endfunction

  // While a cell is transparent or settling, its tristate port must not
  // drive the bus. The consumer takes the value from D instead.
  function automatic void decode_rd(
    input  logic [AW-1:0]   a,
    input  logic            busy,
    input  logic [AW-1:0]   wa,
    output logic [NREG-2:0] en,
    output logic            zero,
    output logic            fwd
  );
    en   = '0;
    zero = 1'b0;
    fwd  = 1'b0;
    if (!addr_ok(a))            zero = 1'b1;
    else if (busy && (a == wa)) fwd  = 1'b1;
    else                        en   = onehot(a);
  endfunction

  assign wready = (state_q != ST_STROBE);

  // Every cell-facing output is computed from the next-state values. It is
  // then registered, so it changes only at clock edges and cannot glitch.
  always_comb begin
    state_d   = state_q;
    wa_d      = wa_q;
    d_d       = d_q;
    ra1_d     = ra1_q;
    ra2_d     = ra2_q;
    wr_accept = bus.WVALID && wready;

    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        // A write to x0 or to an address out of range is accepted and
        // then dropped.
        if (wr_accept && addr_ok(bus.WADDR)) begin
          state_d = ST_STROBE;
          wa_d    = bus.WADDR;
          d_d     = bus.WDATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STROBE: state_d = ST_HOLD;
      default:   state_d = ST_IDLE;
    endcase

    if (bus.RVALID) begin
      ra1_d = bus.RADDR1;
      ra2_d = bus.RADDR2;
    end

    lclk_d = (state_d == ST_STROBE) ? onehot(wa_d) : '0;
    decode_rd(ra1_d, state_d != ST_IDLE, wa_d, en1_d, zero1_d, fwd1_d);
    decode_rd(ra2_d, state_d != ST_IDLE, wa_d, en2_d, zero2_d, fwd2_d);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      wa_q    <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      d_q     <= '0;
      lclk_q  <= '0;
      en1_q   <= '0;
      en2_q   <= '0;
      zero1_q <= 1'b1;
      zero2_q <= 1'b1;
      fwd1_q  <= 1'b0;
      fwd2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wa_q    <= wa_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      d_q     <= d_d;
      lclk_q  <= lclk_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      zero1_q <= zero1_d;
      zero2_q <= zero2_d;
      fwd1_q  <= fwd1_d;
      fwd2_q  <= fwd2_d;
    end
  end

  // Each true signal and its complement come from the same flop. This keeps
  // every pair exactly complementary.
  assign bus.WREADY = wready;
  assign bus.D      = d_q;
  assign bus.LCLK   = lclk_q;
  assign bus.nLCLK  = ~lclk_q;
  assign bus.EN1    = en1_q;
  assign bus.nEN1   = ~en1_q;
  assign bus.EN2    = en2_q;
  assign bus.nEN2   = ~en2_q;
  assign bus.ZERO1  = zero1_q;
  assign bus.ZERO2  = zero2_q;
  assign bus.FWD1   = fwd1_q;
  assign bus.FWD2   = fwd2_q;

endmodule
`default_nettype wire
